// File: rtl/mux_8b_4to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_8b_4to1_pkg
// Shared constants for the 4:1 word multiplexer.
//   SEL_A..SEL_D  : select codes that route a, b, c or d to the output.
//   DEFAULT_WIDTH : default data word width.
// -----------------------------------------------------------------------------
package mux_8b_4to1_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

endpackage : mux_8b_4to1_pkg

// File: rtl/mux2_1.sv
// -----------------------------------------------------------------------------
// mux2_1
// One-bit 2:1 multiplexer cell built from AND/OR/NOT gates.
// Ports:
//   i0 : input,  selected when s = 0
//   i1 : input,  selected when s = 1
//   s  : input,  select
//   y  : output, selected bit
// -----------------------------------------------------------------------------
module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic y
);

  logic w_s_n;
  logic w_p0;
  logic w_p1;
  logic w_pc;

  assign w_s_n = ~s;
  assign w_p0  = i0 & w_s_n;
  assign w_p1  = i1 & s;
  // Consensus term: when both data inputs agree, y equals them even if s is
  // unknown, so equal inputs propagate cleanly through the tree.
  assign w_pc  = i0 & i1;
  assign y     = w_p0 | w_p1 | w_pc;

endmodule : mux2_1

// File: rtl/mux_8b_4to1.sv
// -----------------------------------------------------------------------------
// mux_8b_4to1
// WIDTH-bit 4:1 word multiplexer, built per bit as a two-level tree of mux2_1
// cells, plus a registered copy of the selected word with capture enable.
// Ports:
//   clk   : input,  rising-edge clock for out_q
//   rst   : input,  asynchronous active-high reset (clears out_q)
//   a..d  : input,  data words, selected by sel = 00/01/10/11
//   sel   : input,  word select
//   en    : input,  capture enable for out_q
//   out   : output, combinational selected word (zero latency)
//   out_q : output, registered selected word (one cycle latency)
// -----------------------------------------------------------------------------
module mux_8b_4to1
  import mux_8b_4to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] w_ab;   // level-1 result: a or b by sel[0]
  logic [WIDTH-1:0] w_cd;   // level-1 result: c or d by sel[0]
  logic [WIDTH-1:0] r_out_q;

  // Each bit has its own three-cell tree, so no bit can influence another.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2_1 u_mux_ab (
      .i0 (a[i]),
      .i1 (b[i]),
      .s  (sel[0]),
      .y  (w_ab[i])
    );

    mux2_1 u_mux_cd (
      .i0 (c[i]),
      .i1 (d[i]),
      .s  (sel[0]),
      .y  (w_cd[i])
    );

    mux2_1 u_mux_out (
      .i0 (w_ab[i]),
      .i1 (w_cd[i]),
      .s  (sel[1]),
      .y  (out[i])
    );
  end : g_bit

  // NOTE: non-blocking assignment keeps the register sampling the pre-edge
  // value of out; reset sits in the sensitivity list so it acts without clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
    end else if (en) begin
      r_out_q <= out;
    end
  end

  assign out_q = r_out_q;

endmodule : mux_8b_4to1

// File: tb/tb_mux_8b_4to1.sv
// -----------------------------------------------------------------------------
// tb_mux_8b_4to1
// Self-checking bench for mux_8b_4to1: directed checks with literal expected
// values, then a randomized run compared every cycle against a word-array
// reference model.
// -----------------------------------------------------------------------------
module tb_mux_8b_4to1;
  import mux_8b_4to1_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] out;
  logic [W-1:0] out_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic         chk_en = 1'b0;  // enables the per-cycle compare process
  logic [W-1:0] exp_q  = '0;    // model of the registered output

  mux_8b_4to1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .en    (en),
    .out   (out),
    .out_q (out_q)
  );

  always #5 clk = ~clk;

  // Reference selection: index an array of the four words by the select code.
  function automatic logic [W-1:0] pick(input logic [W-1:0] wa, wb, wc, wd,
                                        input logic [1:0] s);
    logic [W-1:0] words [4];
    words[0] = wa;
    words[1] = wb;
    words[2] = wc;
    words[3] = wd;
    return words[s];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge away from the capture edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rand_out",   out,   pick(a, b, c, d, sel));
      check("rand_out_q", out_q, exp_q);
    end
  end

  initial begin
    logic [W-1:0] pat_exp [4];
    logic [W-1:0] onehot  [4];
    logic [1:0]   s;

    // ---------------- reset ----------------
    rst = 1'b1; en = 1'b0; sel = SEL_A;
    a = 8'h00; b = 8'hFF; c = 8'hAA; d = 8'h55;
    #1;
    check("reset_out_q", out_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- combinational select ----------------
    pat_exp[0] = 8'h00; pat_exp[1] = 8'hFF; pat_exp[2] = 8'hAA; pat_exp[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #5;
      check($sformatf("comb_sel%0d", i), out, pat_exp[i]);
    end

    // ---------------- data change under fixed select ----------------
    sel = SEL_C;
    #1;
    c = 8'h3C;
    #0;
    check("data_change_c", out, 8'h3C);
    a = 8'h12; b = 8'h34; d = 8'h78;
    #0;
    check("other_inputs_ignored", out, 8'h3C);
    a = 8'h00; b = 8'hFF; d = 8'h55;

    // ---------------- async reset ----------------
    @(negedge clk);
    sel = SEL_B; en = 1'b1;
    @(posedge clk); #1;
    check("load_ff", out_q, 8'hFF);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", out_q, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_holds_with_en", out_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- registered capture ----------------
    sel = SEL_D; d = 8'h55; en = 1'b1;
    @(posedge clk); #1;
    check("capture_d", out_q, 8'h55);
    sel = SEL_A;
    #1;
    check("comb_after_sel_change", out, 8'h00);
    check("q_before_edge", out_q, 8'h55);
    @(posedge clk); #1;
    check("capture_a", out_q, 8'h00);

    // ---------------- enable hold ----------------
    en = 1'b0;
    pat_exp[2] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      @(posedge clk); #1;
      check($sformatf("hold_out_sel%0d", i), out, pat_exp[i]);
      check($sformatf("hold_q_sel%0d", i), out_q, 8'h00);
    end

    // ---------------- bitwise independence ----------------
    a = 8'h01; b = 8'h02; c = 8'h04; d = 8'h80;
    onehot[0] = 8'h01; onehot[1] = 8'h02; onehot[2] = 8'h04; onehot[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("onehot_sel%0d", i), out, onehot[i]);
    end

    // ---------------- randomized run against the model ----------------
    @(posedge clk); #1;
    exp_q  = out_q === 8'h00 ? 8'h00 : 8'hxx;  // out_q is 0 here from the hold phase
    exp_q  = 8'h00;
    chk_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      c   = W'($urandom);
      d   = W'($urandom);
      s   = 2'($urandom_range(0, 3));
      sel = s;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 19) == 0);
      if (rst) exp_q = '0;
      @(posedge clk);
      if (rst)     exp_q = '0;
      else if (en) exp_q = pick(a, b, c, d, sel);
      #1;
    end
    chk_en = 1'b0;
    rst    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_8b_4to1
